// File: rtl/micro_pc_sequencer.sv
// micro_pc_sequencer
//   Microprogram counter with a return-address stack. It takes the jump-decision signals and
//   produces the next microinstruction ROM address, one cycle after the inputs are sampled.
//
// Ports
//   CLK          clock; all state updates on the rising edge
//   Reset        synchronous, active-high reset
//   Hold         1 = freeze uPC, stack and flags; all other inputs ignored
//   pre_load     1 = take a non-sequential address this cycle
//   is_BSR       branch-to-subroutine qualifier (push return address, jump to S)
//   is_RET       return qualifier (pop return address into uPC)
//   S            BSR target, zero-extended to ADDR_W
//   D            jump target, low ADDR_W bits used
//   uPC          current microinstruction address (registered)
//   sp_depth     number of valid stack entries
//   stack_full   sp_depth == DEPTH
//   stack_empty  sp_depth == 0
//   stack_ovf    sticky: BSR attempted while full
//   stack_unf    sticky: RET attempted while empty
module micro_pc_sequencer #(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  localparam int unsigned SPW  = $clog2(DEPTH + 1),
  localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Hold,
  input  logic              pre_load,
  input  logic              is_BSR,
  input  logic              is_RET,
  input  logic [9:0]        S,
  input  logic [10:0]       D,
  output logic [ADDR_W-1:0] uPC,
  output logic [SPW-1:0]    sp_depth,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              stack_ovf,
  output logic              stack_unf
);

  localparam logic [SPW-1:0] FullCnt = SPW'(DEPTH);

  logic [ADDR_W-1:0] upc_q, upc_d;
  logic [SPW-1:0]    sp_q, sp_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push_en;
  logic [ADDR_W-1:0] stack_q [DEPTH];

  logic [ADDR_W-1:0] upc_inc;
  logic [ADDR_W-1:0] s_target;
  logic [ADDR_W-1:0] d_target;
  logic [ADDR_W-1:0] top_entry;
  logic [SPW-1:0]    sp_m1;
  logic [IDXW-1:0]   wr_idx;
  logic [IDXW-1:0]   rd_idx;
  logic              is_full;
  logic              is_empty;

  // Zero-extend both targets before trimming so any ADDR_W works.
  logic [ADDR_W+9:0]  s_ext;
  logic [ADDR_W+10:0] d_ext;

  assign s_ext    = {{ADDR_W{1'b0}}, S};
  assign d_ext    = {{ADDR_W{1'b0}}, D};
  assign s_target = s_ext[ADDR_W-1:0];
  assign d_target = d_ext[ADDR_W-1:0];

  assign upc_inc   = upc_q + ADDR_W'(1);
  assign is_full   = (sp_q == FullCnt);
  assign is_empty  = (sp_q == '0);
  assign sp_m1     = sp_q - SPW'(1);
  // Push slot is sp_q itself; only used when not full, so it stays in range.
  assign wr_idx    = sp_q[IDXW-1:0];
  assign rd_idx    = sp_m1[IDXW-1:0];
  assign top_entry = stack_q[rd_idx];

  always_comb begin
    upc_d   = upc_inc;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;
    if (pre_load) begin
      if (is_BSR) begin
        // Jump is taken even when the push has to be dropped.
        upc_d = s_target;
        if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          push_en = 1'b1;
          sp_d    = sp_q + SPW'(1);
        end
      end else if (is_RET) begin
        if (is_empty) begin
          unf_d = 1'b1;
        end else begin
          upc_d = top_entry;
          sp_d  = sp_m1;
        end
      end else begin
        upc_d = d_target;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      upc_q <= RESET_ADDR;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else if (!Hold) begin
      upc_q <= upc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      if (push_en) begin
        stack_q[wr_idx] <= upc_inc;
      end
    end
  end

  assign uPC         = upc_q;
  assign sp_depth    = sp_q;
  assign stack_full  = is_full;
  assign stack_empty = is_empty;
  assign stack_ovf   = ovf_q;
  assign stack_unf   = unf_q;

endmodule
